hdmi_acr_packet_gen: RTL

//  Runtime-configurable HDMI Audio Clock Regeneration (ACR) packet source (HDMI 1.4b 5.3.3 / 7.2.3).

---
 rtl/hdmi_acr_pkg.sv | 44 ++++
 rtl/hdmi_acr_cts_meter.sv | 73 +++++++
 rtl/hdmi_acr_packet_gen.sv | 123 ++++++++++++
 3 files changed

// File: rtl/hdmi_acr_pkg.sv
// Shared types, N table and packet formatting helpers for the HDMI ACR packet source.
package hdmi_acr_pkg;

  typedef enum logic [2:0] {
    Rate32k   = 3'd0,
    Rate44k1  = 3'd1,
    Rate48k   = 3'd2,
    Rate88k2  = 3'd3,
    Rate96k   = 3'd4,
    Rate176k4 = 3'd5,
    Rate192k  = 3'd6
  } acr_rate_e;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeasure
  } acr_state_e;

  localparam logic [19:0] N_TABLE [7] = '{
    20'd4096, 20'd6272, 20'd6144, 20'd12544, 20'd12288, 20'd25088, 20'd24576
  };

  localparam logic [23:0] ACR_HEADER = 24'h000001;

  // Code 7 is not a legal rate; fall back to 48k.
  function automatic acr_rate_e acr_decode(input logic [2:0] sel);
    return (sel == 3'd7) ? Rate48k : acr_rate_e'(sel);
  endfunction

  function automatic logic [19:0] acr_n(input acr_rate_e rate);
    return N_TABLE[rate];
  endfunction

  // One window spans N/128 audio sample periods.
  function automatic logic [11:0] acr_edges(input acr_rate_e rate);
    return 12'(acr_n(rate) >> 7);
  endfunction

  function automatic logic [55:0] acr_subpkt(input logic [19:0] n, input logic [19:0] cts);
    return {n[7:0], n[15:8], 4'd0, n[19:16], cts[7:0], cts[15:8], 4'd0, cts[19:16], 8'd0};
  endfunction

endpackage

// File: rtl/hdmi_acr_cts_meter.sv
// Counts clk_pixel cycles across a window of sampled clk_audio rising edges and flags
// loss of clk_audio activity.
module hdmi_acr_cts_meter #(
  parameter int unsigned AvgLog2       = 0,
  parameter int unsigned TimeoutCycles = 4096,
  parameter logic [19:0] CtsMax        = 20'hFFFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        aud_i,
  input  logic        arm_i,
  input  logic        meas_i,
  input  logic [11:0] edges_i,
  output logic        aud_edge_o,
  output logic        timeout_o,
  output logic        cts_strobe_o,
  output logic [19:0] cts_o
);

  localparam int unsigned PixW = 20 + AvgLog2;
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
  localparam logic [PixW:0] CtsMaxW = {{(PixW - 19){1'b0}}, CtsMax};

  logic [2:0]      sync_q, sync_d;
  logic [PixW-1:0] pix_q, pix_d;
  logic [11:0]     edg_q, edg_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [PixW:0]   pix_inc, cts_wide;
  logic            aud_edge, run, window_end;

  always_comb begin
    sync_d     = {sync_q[1:0], aud_i};
    aud_edge   = sync_q[1] & ~sync_q[2];
    run        = arm_i | meas_i;
    timeout_o  = run & ~aud_edge & (tmo_q == TmoLast);
    tmo_d      = (!run || aud_edge || timeout_o) ? '0 : tmo_q + TmoW'(1);
    window_end = meas_i & aud_edge & ((edg_q + 12'd1) == edges_i);

    // The ending edge is the start of the next window, hence the +1.
    pix_inc    = {1'b0, pix_q} + (PixW + 1)'(1);
    cts_wide   = pix_inc >> AvgLog2;
    cts_o      = (cts_wide > CtsMaxW) ? CtsMax : cts_wide[19:0];

    pix_d = pix_q;
    edg_d = edg_q;
    if (!meas_i || window_end) begin
      pix_d = '0;
      edg_d = '0;
    end else begin
      pix_d = (&pix_q) ? pix_q : pix_q + PixW'(1);
      if (aud_edge) edg_d = edg_q + 12'd1;
    end
  end

  assign aud_edge_o   = aud_edge;
  assign cts_strobe_o = window_end;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      pix_q  <= '0;
      edg_q  <= '0;
      tmo_q  <= '0;
    end else begin
      sync_q <= sync_d;
      pix_q  <= pix_d;
      edg_q  <= edg_d;
      tmo_q  <= tmo_d;
    end
  end

endmodule

// File: rtl/hdmi_acr_packet_gen.sv
// HDMI Audio Clock Regeneration packet source: rate decode, measurement FSM and a
// single-entry packet register offered to the data-island scheduler.
module hdmi_acr_packet_gen
  import hdmi_acr_pkg::*;
#(
  parameter int unsigned AVG_LOG2       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [19:0] CTS_MAX        = 20'hFFFFF
) (
  input  logic         clk_pixel,
  input  logic         reset_n,
  input  logic         clk_audio,
  input  logic         enable,
  input  logic [2:0]   rate_sel,
  input  logic         pkt_ready,
  output logic         pkt_valid,
  output logic [23:0]  header,
  output logic [223:0] sub,
  output logic [19:0]  cts,
  output logic [19:0]  n_value,
  output logic         locked,
  output logic         overrun
);

  acr_state_e  state_q, state_d;
  acr_rate_e   rate_q, rate_d;
  logic [19:0] cts_q, cts_d, pkt_n_q, pkt_n_d;
  logic        valid_q, valid_d, locked_q, locked_d, overrun_q, overrun_d;
  logic        rate_chg, arm, meas, aud_edge, timeout, cts_strobe, publish;
  logic [19:0] cts_meas;
  logic [11:0] edges;

  assign rate_d   = acr_decode(rate_sel);
  assign rate_chg = (rate_d != rate_q);
  assign edges    = acr_edges(rate_q) << AVG_LOG2;

  hdmi_acr_cts_meter #(
    .AvgLog2      (AVG_LOG2),
    .TimeoutCycles(TIMEOUT_CYCLES),
    .CtsMax       (CTS_MAX)
  ) u_meter (
    .clk_i       (clk_pixel),
    .rst_ni      (reset_n),
    .aud_i       (clk_audio),
    .arm_i       (arm),
    .meas_i      (meas),
    .edges_i     (edges),
    .aud_edge_o  (aud_edge),
    .timeout_o   (timeout),
    .cts_strobe_o(cts_strobe),
    .cts_o       (cts_meas)
  );

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:    state_d = StArm;
        StArm:     if (!rate_chg && !timeout && aud_edge) state_d = StMeasure;
        StMeasure: if (rate_chg || timeout) state_d = StArm;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    arm  = (state_q == StArm);
    meas = (state_q == StMeasure);
  end

  // A window that completes in the same cycle as a rate change belongs to the old rate.
  always_comb begin
    publish   = cts_strobe & enable & ~rate_chg;
    cts_d     = publish ? cts_meas : cts_q;
    pkt_n_d   = publish ? acr_n(rate_q) : pkt_n_q;

    valid_d   = valid_q & ~pkt_ready;
    if (publish) valid_d = 1'b1;
    if (!enable || timeout) valid_d = 1'b0;

    locked_d  = locked_q;
    if (publish) locked_d = 1'b1;
    if (!enable || timeout || rate_chg) locked_d = 1'b0;

    overrun_d = overrun_q;
    if (publish && valid_q && !pkt_ready) overrun_d = 1'b1;
    if (!enable) overrun_d = 1'b0;
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      rate_q    <= Rate48k;
      cts_q     <= '0;
      pkt_n_q   <= 20'd6144;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rate_q    <= rate_d;
      cts_q     <= cts_d;
      pkt_n_q   <= pkt_n_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      overrun_q <= overrun_d;
    end
  end

  assign pkt_valid = valid_q;
  assign header    = ACR_HEADER;
  assign sub       = {4{acr_subpkt(pkt_n_q, cts_q)}};
  assign cts       = cts_q;
  assign n_value   = acr_n(rate_q);
  assign locked    = locked_q;
  assign overrun   = overrun_q;

endmodule
